pipelined_subtractor: RTL and testbench

//  Computes DIFF = A - B - BIN over WIDTH bits as a ripple-borrow full-subtractor chain.
//  The chain is cut into STAGES register-separated slices, so one result can complete every cycle.
//  It is the subtract-direction counterpart to the team's full-adder ripple datapath.

---
 rtl/pipelined_subtractor_if.sv | 25 ++
 rtl/pipelined_subtractor.sv | 127 ++++++++++++
 tb/tb_pipelined_subtractor.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_subtractor_if.sv
// Valid/ready bus for pipelined_subtractor: operand side (a, b, bin) and result side (diff, borrow, overflow).
interface pipelined_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow, overflow
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow, overflow
  );
endinterface

// File: rtl/pipelined_subtractor.sv
// Pipelined ripple-borrow subtractor: diff = a - b - bin, cut into STAGES slices of WIDTH/STAGES bits.
// Optional macro SUB_OVERFLOW_EN adds a registered signed-overflow flag; otherwise overflow is tied to 0.
module pipelined_subtractor #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_subtractor_if.slave bus
);

  // WIDTH must be a multiple of STAGES; each slice resolves SW bits.
  localparam int SW = WIDTH / STAGES;

  logic             stall;
  logic             out_v;
  logic             out_bo;
  logic [WIDTH-1:0] out_d;
  logic             out_ov;

  // link_*[k] is what slice k consumes: the previous slice's registers, or the input bus for slice 0.
  logic             link_v  [STAGES];
  logic             link_bo [STAGES];
  logic [WIDTH-1:0] link_d  [STAGES];
  logic [WIDTH-1:0] link_a  [STAGES];
  logic [WIDTH-1:0] link_b  [STAGES];

  assign stall        = out_v & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  assign link_v[0]  = bus.in_valid;
  assign link_bo[0] = bus.bin;
  assign link_d[0]  = '0;
  assign link_a[0]  = bus.a;
  assign link_b[0]  = bus.b;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [SW:0]      br;
    logic [SW-1:0]    ds;
    logic [WIDTH-1:0] d_next;
    logic             v_q;
    logic             bo_q;
    logic [WIDTH-1:0] d_q;

    assign br[0] = link_bo[k];

    // Operand skew keeps the unprocessed bits at the bottom, so every slice reads bits [SW-1:0].
    for (genvar i = 0; i < SW; i++) begin : g_cell
      logic a_bit;
      logic b_bit;
      assign a_bit   = link_a[k][i];
      assign b_bit   = link_b[k][i];
      assign ds[i]   = a_bit ^ b_bit ^ br[i];
      assign br[i+1] = (~a_bit & b_bit) | (~a_bit & br[i]) | (b_bit & br[i]);
    end

    always_comb begin
      d_next                = link_d[k];
      d_next[k*SW +: SW]    = ds;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q  <= 1'b0;
        bo_q <= 1'b0;
        d_q  <= '0;
      end else if (!stall) begin
        v_q <= link_v[k];
        if (link_v[k]) begin
          bo_q <= br[SW];
          d_q  <= d_next;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall && link_v[k]) begin
          a_q <= link_a[k] >> SW;
          b_q <= link_b[k] >> SW;
        end
      end

      assign link_v[k+1]  = v_q;
      assign link_bo[k+1] = bo_q;
      assign link_d[k+1]  = d_q;
      assign link_a[k+1]  = a_q;
      assign link_b[k+1]  = b_q;
    end else begin : g_last
      assign out_v  = v_q;
      assign out_bo = bo_q;
      assign out_d  = d_q;

`ifdef SUB_OVERFLOW_EN
      logic a_msb_q;
      logic b_msb_q;

      // The operand sign bits are only visible to the last slice, so they are captured here.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_msb_q <= 1'b0;
          b_msb_q <= 1'b0;
        end else if (!stall && link_v[k]) begin
          a_msb_q <= link_a[k][SW-1];
          b_msb_q <= link_b[k][SW-1];
        end
      end

      assign out_ov = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_q[WIDTH-1]);
`else
      assign out_ov = 1'b0;
`endif
    end
  end

  assign bus.out_valid = out_v;
  assign bus.diff      = out_d;
  assign bus.borrow    = out_bo;
  assign bus.overflow  = out_ov;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Scoreboard bench for pipelined_subtractor (WIDTH=8, STAGES=4); overflow expectations follow SUB_OVERFLOW_EN.
module tb_pipelined_subtractor;

  localparam int WIDTH    = 8;
  localparam int STAGES   = 4;
  localparam int EXP_OUTS = 16;
`ifdef SUB_OVERFLOW_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  typedef logic [WIDTH+1:0] res_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   n_out       = 0;
  int   lat;
  res_t sb [$];

  always #5 clk = ~clk;

  pipelined_subtractor_if #(.WIDTH(WIDTH)) bus ();

  pipelined_subtractor #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: wide unsigned subtract gives diff and borrow; overflow from the operand/result signs.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] full;
    logic       ov;
    full = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    ov   = OV_EN & (a[7] ^ b[7]) & (a[7] ^ full[7]);
    return {full[7:0], full[8], ov};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Results are compared against the queue head; a held result must match the head every stalled cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid) begin
        check("spurious_output", 32'(sb.size() == 0), 32'd0);
        if (sb.size() > 0) begin
          if (bus.out_ready) check("result", 32'({bus.diff, bus.borrow, bus.overflow}), 32'(sb[0]));
          else               check("stall_hold", 32'({bus.diff, bus.borrow, bus.overflow}), 32'(sb[0]));
        end
        if (bus.out_ready) begin
          n_out++;
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.a, bus.b, bus.bin));
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit hold);
    int waited = 0;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.out_valid && cycles < 20);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic op_check(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] exp_diff, input logic exp_borrow, input logic exp_ov);
    int l;
    send(a, b, bin, 1'b0);
    wait_valid(l);
    check({tag, "_latency"}, 32'(l), 32'(STAGES));
    check(tag, 32'({bus.out_valid, bus.diff, bus.borrow, bus.overflow}),
          32'({1'b1, exp_diff, exp_borrow, exp_ov}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.out_valid, bus.diff, bus.borrow, bus.overflow}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    op_check("basic_35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

    op_check("bnd_0_1",    8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op_check("bnd_0_ff_b", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
    op_check("bnd_equal",  8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    op_check("bnd_0_0_b",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

    send(8'h10, 8'h01, 1'b0, 1'b1);
    send(8'h20, 8'h02, 1'b0, 1'b1);
    send(8'h30, 8'h03, 1'b0, 1'b0);
    wait_valid(lat);
    check("b2b_0", 32'({bus.out_valid, bus.diff}), 32'({1'b1, 8'h0F}));
    @(negedge clk);
    check("b2b_1", 32'({bus.out_valid, bus.diff}), 32'({1'b1, 8'h1E}));
    @(negedge clk);
    check("b2b_2", 32'({bus.out_valid, bus.diff}), 32'({1'b1, 8'h2D}));
    drain();

    bus.out_ready = 1'b0;
    send(8'h10, 8'h01, 1'b0, 1'b0);
    send(8'h50, 8'h05, 1'b0, 1'b0);
    send(8'h60, 8'h06, 1'b0, 1'b0);
    wait_valid(lat);
    @(posedge clk);
    #1;
    bus.a        = 8'h70;
    bus.b        = 8'h07;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_diff", 32'({bus.out_valid, bus.diff}), 32'({1'b1, 8'h0F}));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();

    op_check("ov_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OV_EN);
    op_check("ov_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, OV_EN);
    op_check("ov_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    send(8'hA0, 8'h01, 1'b0, 1'b1);
    send(8'hB0, 8'h02, 1'b0, 1'b1);
    send(8'hC0, 8'h03, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midpipe_reset", 32'({bus.out_valid, bus.diff, bus.borrow, bus.overflow}), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    op_check("post_reset", 8'h44, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);
    drain();

    check("result_count", 32'(n_out), 32'(EXP_OUTS));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
